// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared encodings for the byte-serial memory controller.
//   - FSM state encodings (IDLE/READ/WRITE/DONE)
//   - LSB access-size encodings and the default IO region tag
//   - helpers: size code -> byte count, byte lane extraction
package mem_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // addr[17:16] value marking the IO region (0x30000 and up)
  localparam logic [1:0] IO_BASE_HI_DEF = 2'b11;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_LSB = 1'b1
  } owner_e;

  // Number of bus bytes for an LSB size code; unused code 3 is treated as a word.
  function automatic logic [2:0] size_to_n(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: size_to_n = 3'd1;
      SZ_HALF: size_to_n = 3'd2;
      default: size_to_n = 3'd4;
    endcase
  endfunction

  // Little-endian byte lane of a 32-bit word.
  function automatic logic [7:0] byte_lane(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    byte_lane = w[7:0];
      2'd1:    byte_lane = w[15:8];
      2'd2:    byte_lane = w[23:16];
      default: byte_lane = w[31:24];
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises ICache fetches and LSB loads/stores onto a byte-wide
// RAM/IO bus. LSB has priority; a started transaction is never preempted.
// Ports:
//   clk, rst (async, active-low), rdy (global hold), clear (read rollback)
//   io_buffer_full            - IO write path cannot accept a store
//   mem_din/mem_dout/mem_a/mem_wr - byte bus (1-cycle read latency RAM)
//   if_addr_enable/if_addr    - fetch request; if_valid/if_inst response
//   lsb_enable/lsb_wr/lsb_size/lsb_addr/lsb_wdata - data request
//   lsb_valid/lsb_rdata       - data response (zero-extended raw bytes)
// All outputs come straight from registers.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [1:0] IO_BASE_HI = IO_BASE_HI_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic        io_buffer_full,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        if_addr_enable,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_inst,
  input  logic        lsb_enable,
  input  logic        lsb_wr,
  input  logic [1:0]  lsb_size,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_wdata,
  output logic        lsb_valid,
  output logic [31:0] lsb_rdata
);

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;       // index of the next clock edge, E(cnt)
  logic [2:0]  n_q, n_d;
  logic [31:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d;
  owner_e      owner_q, owner_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        lsb_valid_q, lsb_valid_d;
  logic [31:0] lsb_rdata_q, lsb_rdata_d;

  logic lsb_io_stall;
  logic lsb_accept;
  logic if_accept;

  // An IO store facing a full buffer is refused, and it still blocks the
  // fetch so the LSB keeps its priority.
  assign lsb_io_stall = lsb_wr && (lsb_addr[17:16] == IO_BASE_HI) && io_buffer_full;
  assign lsb_accept   = lsb_enable && !lsb_io_stall;
  assign if_accept    = !lsb_enable && if_addr_enable && !clear;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    owner_d     = owner_q;
    asm_d       = asm_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    mem_wr_d    = mem_wr_q;
    if_valid_d  = 1'b0;
    if_inst_d   = if_inst_q;
    lsb_valid_d = 1'b0;
    lsb_rdata_d = lsb_rdata_q;

    case (state_q)
      ST_IDLE: begin
        mem_wr_d = 1'b0;
        if (lsb_accept) begin
          base_d   = lsb_addr;
          n_d      = size_to_n(lsb_size);
          wdata_d  = lsb_wdata;
          owner_d  = OWN_LSB;
          asm_d    = '0;
          cnt_d    = 3'd1;
          mem_a_d  = lsb_addr;
          mem_wr_d = lsb_wr;
          if (lsb_wr) begin
            mem_dout_d = lsb_wdata[7:0];
            state_d    = ST_WRITE;
          end else begin
            state_d    = ST_READ;
          end
        end else if (if_accept) begin
          base_d   = if_addr;
          n_d      = 3'd4;
          owner_d  = OWN_IF;
          asm_d    = '0;
          cnt_d    = 3'd1;
          mem_a_d  = if_addr;
          state_d  = ST_READ;
        end
      end

      ST_READ: begin
        if (clear) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          mem_a_d = '0;
        end else begin
          // RAM returns byte k two edges after its address is driven.
          case (cnt_q)
            3'd2:    asm_d[7:0]   = mem_din;
            3'd3:    asm_d[15:8]  = mem_din;
            3'd4:    asm_d[23:16] = mem_din;
            3'd5:    asm_d[31:24] = mem_din;
            default: ;
          endcase
          if (cnt_q < n_q) begin
            mem_a_d = base_q + 32'(cnt_q);
          end
          if (cnt_q == n_q + 3'd1) begin
            state_d = ST_DONE;
            cnt_d   = '0;
            if (owner_q == OWN_LSB) begin
              lsb_rdata_d = asm_d;
              lsb_valid_d = 1'b1;
            end else begin
              if_inst_d   = asm_d;
              if_valid_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      ST_WRITE: begin
        if (cnt_q < n_q) begin
          mem_a_d    = base_q + 32'(cnt_q);
          mem_dout_d = byte_lane(wdata_q, cnt_q[1:0]);
          mem_wr_d   = 1'b1;
          cnt_d      = cnt_q + 3'd1;
        end else begin
          mem_wr_d    = 1'b0;
          mem_a_d     = '0;
          lsb_valid_d = 1'b1;
          state_d     = ST_DONE;
          cnt_d       = '0;
        end
      end

      default: begin
        // DONE: requesters still hold their enable here, so nothing is accepted.
        mem_wr_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      n_q         <= '0;
      base_q      <= '0;
      wdata_q     <= '0;
      owner_q     <= OWN_IF;
      asm_q       <= '0;
      mem_a_q     <= '0;
      mem_dout_q  <= '0;
      mem_wr_q    <= 1'b0;
      if_valid_q  <= 1'b0;
      if_inst_q   <= '0;
      lsb_valid_q <= 1'b0;
      lsb_rdata_q <= '0;
    end else if (rdy) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      owner_q     <= owner_d;
      asm_q       <= asm_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
      if_valid_q  <= if_valid_d;
      if_inst_q   <= if_inst_d;
      lsb_valid_q <= lsb_valid_d;
      lsb_rdata_q <= lsb_rdata_d;
    end
  end

  // A mem_wr held high while rdy=0 is gated by the enclosing top level.
  assign mem_a     = mem_a_q;
  assign mem_dout  = mem_dout_q;
  assign mem_wr    = mem_wr_q;
  assign if_valid  = if_valid_q;
  assign if_inst   = if_inst_q;
  assign lsb_valid = lsb_valid_q;
  assign lsb_rdata = lsb_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: scoreboard bench for mem_ctrl. Stimulus pushes expected
// responses and bus writes into queues; a negedge monitor pops and compares.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, clear, io_buffer_full;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        if_addr_enable;
  logic [31:0] if_addr;
  logic        if_valid;
  logic [31:0] if_inst;
  logic        lsb_enable, lsb_wr;
  logic [1:0]  lsb_size;
  logic [31:0] lsb_addr, lsb_wdata;
  logic        lsb_valid;
  logic [31:0] lsb_rdata;

  always #5 clk = ~clk;

  mem_ctrl #(.IO_BASE_HI(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .io_buffer_full(io_buffer_full),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .if_addr_enable(if_addr_enable), .if_addr(if_addr),
    .if_valid(if_valid), .if_inst(if_inst),
    .lsb_enable(lsb_enable), .lsb_wr(lsb_wr), .lsb_size(lsb_size),
    .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata),
    .lsb_valid(lsb_valid), .lsb_rdata(lsb_rdata)
  );

  // Byte RAM with one-cycle registered read; IO region writes are not stored.
  logic [7:0] ram [0:65535];
  always @(posedge clk) begin
    mem_din <= ram[mem_a[15:0]];
    if (mem_wr && rdy && mem_a[17:16] != 2'b11) ram[mem_a[15:0]] <= mem_dout;
  end

  typedef struct packed { logic st; logic [31:0] d; } lsb_exp_t;
  typedef struct packed { logic [31:0] a; logic [7:0] d; } wr_t;

  logic [31:0] exp_if_q[$];
  lsb_exp_t    exp_lsb_q[$];
  wr_t         exp_wr_q[$];

  int unsigned n_cmp = 0, n_err = 0, cyc = 0;
  int unsigned t_l, t_i;
  logic prev_if = 1'b0, prev_lsb = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst) begin
      if (if_valid && lsb_valid) check("valid_overlap", 32'({if_valid, lsb_valid}), 32'd0);
      if (if_valid) begin
        check("if_valid_width", 32'(prev_if), 32'd0);
        if (exp_if_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL if_unexpected: if_valid=1 inst=0x%08h, required no pulse", if_inst);
        end else check("if_inst", if_inst, exp_if_q.pop_front());
      end
      if (lsb_valid) begin
        check("lsb_valid_width", 32'(prev_lsb), 32'd0);
        if (exp_lsb_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL lsb_unexpected: lsb_valid=1 rdata=0x%08h, required no pulse", lsb_rdata);
        end else begin
          lsb_exp_t e;
          e = exp_lsb_q.pop_front();
          if (!e.st) check("lsb_rdata", lsb_rdata, e.d);
        end
      end
      if (mem_wr && rdy) begin
        if (exp_wr_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL wr_unexpected: write a=0x%08h d=0x%02h, required none", mem_a, mem_dout);
        end else begin
          wr_t w;
          w = exp_wr_q.pop_front();
          check("wr_addr", mem_a, w.a);
          check("wr_data", 32'(mem_dout), 32'(w.d));
        end
      end
      prev_if  <= if_valid;
      prev_lsb <= lsb_valid;
    end else begin
      prev_if  <= 1'b0;
      prev_lsb <= 1'b0;
    end
  end

  task automatic start_if(input logic [31:0] a, input logic [31:0] exp);
    exp_if_q.push_back(exp);
    if_addr = a;
    if_addr_enable = 1'b1;
  endtask

  task automatic start_lsb(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] exp);
    exp_lsb_q.push_back('{st: wr, d: exp});
    lsb_wr = wr; lsb_size = sz; lsb_addr = a; lsb_wdata = wd;
    lsb_enable = 1'b1;
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [7:0] d);
    exp_wr_q.push_back('{a: a, d: d});
  endtask

  // Requester handshake: hold enable until valid is seen, drop it one edge later.
  task automatic wait_valid(input bit is_lsb, output int unsigned stamp);
    int unsigned k = 0;
    stamp = 0;
    while ((is_lsb ? lsb_valid : if_valid) !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if ((is_lsb ? lsb_valid : if_valid) !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL %s_timeout: no valid within 40 cycles, required one pulse", is_lsb ? "lsb" : "if");
    end else stamp = cyc;
    @(negedge clk);
    if (is_lsb) lsb_enable = 1'b0; else if_addr_enable = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
    if_addr_enable = 1'b0; if_addr = '0;
    lsb_enable = 1'b0; lsb_wr = 1'b0; lsb_size = '0; lsb_addr = '0; lsb_wdata = '0;
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h0100] = 8'h13; ram[16'h0101] = 8'h05; ram[16'h0102] = 8'hA0; ram[16'h0103] = 8'h00;
    ram[16'h0200] = 8'h78; ram[16'h0201] = 8'h56; ram[16'h0202] = 8'h34; ram[16'h0203] = 8'h12;
    ram[16'h1002] = 8'h5A;
    ram[16'hFFFE] = 8'hAA; ram[16'hFFFF] = 8'hBB; ram[16'h0000] = 8'hCC; ram[16'h0001] = 8'hDD;
    #1 rst = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_dout", 32'(mem_dout), 32'h0);
    check("rst_mem_wr", 32'(mem_wr), 32'h0);
    check("rst_if_valid", 32'(if_valid), 32'h0);
    check("rst_if_inst", if_inst, 32'h0);
    check("rst_lsb_valid", 32'(lsb_valid), 32'h0);
    check("rst_lsb_rdata", lsb_rdata, 32'h0);
    #2 rst = 1'b1;

    // Fetch: address stepping and 5-edge latency; enable held through DONE
    @(negedge clk);
    start_if(32'h100, 32'h00A00513);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("fetch_addr", mem_a, 32'h100 + 32'(k));
      check("fetch_wr", 32'(mem_wr), 32'h0);
    end
    @(negedge clk); check("fetch_lat_e4", 32'(if_valid), 32'h0);
    @(negedge clk); check("fetch_lat_e5", 32'(if_valid), 32'h1);
    @(negedge clk); if_addr_enable = 1'b0;
    repeat (8) @(negedge clk);

    // Priority: LSB first, fetch accepted on the first IDLE edge after DONE
    start_lsb(1'b0, 2'd2, 32'h200, 32'h0, 32'h12345678);
    start_if(32'h100, 32'h00A00513);
    fork
      wait_valid(1'b1, t_l);
      wait_valid(1'b0, t_i);
    join
    check("prio_gap", t_i - t_l, 32'd7);
    repeat (4) @(negedge clk);

    // Store half
    push_wr(32'h1000, 8'hEF); push_wr(32'h1001, 8'hBE);
    start_lsb(1'b1, 2'd1, 32'h1000, 32'hDEADBEEF, 32'h0);
    wait_valid(1'b1, t_l);
    repeat (3) @(negedge clk);
    check("store_half_untouched", 32'(ram[16'h1002]), 32'h5A);
    check("store_half_drained", 32'(exp_wr_q.size()), 32'h0);

    // Byte load (zero-extended) and word load wrapping past 0xFFFFFFFF
    start_lsb(1'b0, 2'd0, 32'h1001, 32'h0, 32'h000000BE);
    wait_valid(1'b1, t_l);
    start_lsb(1'b0, 2'd2, 32'hFFFFFFFE, 32'h0, 32'hDDCCBBAA);
    wait_valid(1'b1, t_l);
    repeat (3) @(negedge clk);

    // IO stall: store to IO region with buffer full blocks the fetch too
    io_buffer_full = 1'b1;
    start_lsb(1'b1, 2'd0, 32'h30000, 32'h00000041, 32'h0);
    start_if(32'h100, 32'h00A00513);
    repeat (10) begin
      @(negedge clk);
      check("io_stall_wr", 32'(mem_wr), 32'h0);
      check("io_stall_if", 32'(if_valid), 32'h0);
    end
    push_wr(32'h30000, 8'h41);
    io_buffer_full = 1'b0;
    fork
      wait_valid(1'b1, t_l);
      wait_valid(1'b0, t_i);
    join
    check("io_drained", 32'(exp_wr_q.size()), 32'h0);
    repeat (3) @(negedge clk);

    // Rollback on the 3rd cycle of a fetch
    if_addr = 32'h100; if_addr_enable = 1'b1;
    @(negedge clk); @(negedge clk); @(negedge clk);
    clear = 1'b1; if_addr_enable = 1'b0;
    @(negedge clk);
    check("clear_mem_a", mem_a, 32'h0);
    check("clear_mem_wr", 32'(mem_wr), 32'h0);
    clear = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("clear_no_wr", 32'(mem_wr), 32'h0);
    end
    // Fetch is not accepted while clear is high
    if_addr = 32'h100; if_addr_enable = 1'b1; clear = 1'b1;
    @(negedge clk);
    check("clear_blocks_fetch", mem_a, 32'h0);
    clear = 1'b0;
    exp_if_q.push_back(32'h00A00513);
    wait_valid(1'b0, t_i);
    repeat (3) @(negedge clk);

    // Clear during a word store has no effect
    push_wr(32'h1004, 8'h44); push_wr(32'h1005, 8'h33);
    push_wr(32'h1006, 8'h22); push_wr(32'h1007, 8'h11);
    start_lsb(1'b1, 2'd2, 32'h1004, 32'h11223344, 32'h0);
    @(negedge clk); @(negedge clk);
    clear = 1'b1;
    @(negedge clk); @(negedge clk);
    clear = 1'b0;
    wait_valid(1'b1, t_l);
    check("clear_store_drained", 32'(exp_wr_q.size()), 32'h0);
    start_lsb(1'b0, 2'd1, 32'h1005, 32'h0, 32'h00002233);
    wait_valid(1'b1, t_l);
    repeat (3) @(negedge clk);

    // rdy=0 mid store: address and data hold
    push_wr(32'h1010, 8'h0D); push_wr(32'h1011, 8'h0C);
    push_wr(32'h1012, 8'h0B); push_wr(32'h1013, 8'h0A);
    start_lsb(1'b1, 2'd2, 32'h1010, 32'h0A0B0C0D, 32'h0);
    @(negedge clk); @(negedge clk);
    #2 rdy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rdy_hold_a", mem_a, 32'h1011);
      check("rdy_hold_d", 32'(mem_dout), 32'h0C);
    end
    #2 rdy = 1'b1;
    wait_valid(1'b1, t_l);
    check("rdy_store_drained", 32'(exp_wr_q.size()), 32'h0);
    repeat (3) @(negedge clk);

    // Async reset mid word store
    push_wr(32'h1008, 8'h0D); push_wr(32'h1009, 8'hF0);
    lsb_wr = 1'b1; lsb_size = 2'd2; lsb_addr = 32'h1008; lsb_wdata = 32'hCAFEF00D;
    lsb_enable = 1'b1;
    @(negedge clk); @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("areset_mem_wr", 32'(mem_wr), 32'h0);
    check("areset_mem_a", mem_a, 32'h0);
    check("areset_mem_dout", 32'(mem_dout), 32'h0);
    check("areset_lsb_valid", 32'(lsb_valid), 32'h0);
    check("areset_if_inst", if_inst, 32'h0);
    check("areset_lsb_rdata", lsb_rdata, 32'h0);
    lsb_enable = 1'b0;
    repeat (2) @(negedge clk);
    check("areset_ram_byte2", 32'(ram[16'h100A]), 32'h0);
    check("areset_ram_byte0", 32'(ram[16'h1008]), 32'h0D);
    #2 rst = 1'b1;
    @(negedge clk);
    start_if(32'h100, 32'h00A00513);
    wait_valid(1'b0, t_i);
    repeat (5) @(negedge clk);

    check("end_if_q", 32'(exp_if_q.size()), 32'h0);
    check("end_lsb_q", 32'(exp_lsb_q.size()), 32'h0);
    check("end_wr_q", 32'(exp_wr_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory controller directly downstream of the instruction cache. It also serves the load/store buffer (LSB).
- Turns a 32-bit instruction fetch, or a 1/2/4-byte data access, into sequential single-byte transactions on the byte-wide RAM/IO bus.
- Assembles or splits the data little-endian and returns it with a one-cycle valid pulse.
- Arbitrates between the two requesters; LSB has priority. No preemption once a transaction has started.

Parameters:
- IO_BASE_HI, 2'b11, value of addr[17:16] that marks the IO region (0x30000 and up).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low (asserted when 0)
- rdy  in  1  global enable; when 0, every register holds its value
- clear  in  1  pipeline rollback; aborts in-flight reads
- io_buffer_full  in  1  IO output buffer cannot accept a write
- mem_din  in  8  RAM/IO read byte
- mem_dout  out  8  RAM/IO write byte
- mem_a  out  32  byte address
- mem_wr  out  1  1 = write, 0 = read
- if_addr_enable  in  1  ICache fetch request; held high until served
- if_addr  in  32  fetch address, word-aligned
- if_valid  out  1  one-cycle pulse: if_inst is valid
- if_inst  out  32  fetched instruction, little-endian
- lsb_enable  in  1  LSB request; held high until served
- lsb_wr  in  1  1 = store
- lsb_size  in  2  0 = byte, 1 = half, 2 = word (n = 1/2/4 bytes)
- lsb_addr  in  32  data address
- lsb_wdata  in  32  store data; low n bytes are used
- lsb_valid  out  1  one-cycle pulse: access complete
- lsb_rdata  out  32  load data, zero-extended raw bytes; sign extension is done in the LSB

Behaviour:
- All outputs are registered.
- Reset values: mem_a=0, mem_dout=0, mem_wr=0, if_valid=0, if_inst=0, lsb_valid=0, lsb_rdata=0, state=IDLE, byte counter=0.
- States: IDLE, READ, WRITE, DONE.
- IDLE, at a clock edge:
  - If lsb_enable is high, accept the LSB request. Otherwise, if if_addr_enable is high and clear is low, accept the fetch.
  - Latch base address, n, write data and owner.
  - Drive mem_a=base, with mem_wr=lsb_wr for an LSB access or 0 for a fetch, and mem_dout=byte0 for a store.
- IO stall: an LSB store with lsb_addr[17:16]==IO_BASE_HI while io_buffer_full=1 is not accepted. The controller stays in IDLE, and the IF request is not served in its place; the LSB keeps priority. This check applies at acceptance only; the IO write path buffers one byte.
- READ (acceptance edge E0):
  - Byte k is captured from mem_din at edge E(k+2).
  - mem_a=base+k is driven from E(k) for k<n.
  - At edge E(n+1), the assembled word is written to if_inst or lsb_rdata, the matching valid is set to 1, and state goes to DONE.
  - Word latency: valid is visible in the cycle after E5.
- WRITE:
  - At edge E(k) for k<n: mem_a=base+k, mem_dout=byte k, mem_wr=1.
  - At edge E(n): mem_wr=0, mem_a=0, lsb_valid=1, state goes to DONE.
- DONE:
  - Valid returns to 0; state goes to IDLE.
  - No request is accepted in DONE. This is mandatory: the ICache drops if_addr_enable one edge after it sees if_valid, and the LSB does the same after lsb_valid.
- Valid pulses are exactly one cycle wide and never asserted together.
- Address arithmetic is 32-bit and wraps at 0xFFFFFFFF. There are no alignment checks.
- mem_wr is 0 in every state other than WRITE.
- clear=1 during READ:
  - Abort; go to IDLE at that edge; no valid pulse; mem_a=0.
  - A fetch request is not accepted in the same cycle clear is high.
- clear during WRITE has no effect; committed stores always complete.
- clear during DONE: the valid already set is cancelled, i.e. driven 0 that edge.
- rdy=0: state, counter and outputs hold. A held mem_wr=1 is gated at top level.
- Reset asserted mid-transaction: all registers return to reset values immediately (asynchronous). The partial transfer is discarded.

Decomposition:
- config.v (shared): state encodings (IDLE/READ/WRITE/DONE), LSB size encodings, IO_BASE_HI, and the existing TRUE/FALSE/HIGH/LOW macros.
- No sub-module. Byte assembly and lane select are a small case block inside mem_ctrl.

Test Plan:
- Fetch: if_addr_enable=1, if_addr=0x100, RAM[0x100..0x103]=13 05 A0 00 -> mem_a steps 0x100..0x103 with mem_wr=0; if_inst=0x00A00513 and if_valid=1 for exactly one cycle, 5 edges after acceptance; no second fetch is started while if_addr_enable is still high in DONE.
- Priority: lsb_enable (load, size=2, addr 0x200) and if_addr_enable asserted together -> LSB served first, lsb_valid pulses; the fetch is then accepted on the first IDLE cycle after DONE.
- Store half: lsb_wr=1, size=1, addr 0x1000, wdata=0xDEADBEEF -> mem_wr=1 for 2 cycles, bytes EF then BE at 0x1000/0x1001; lsb_valid pulses; RAM[0x1002] unchanged.
- IO stall: store byte 0x41 to 0x30000 with io_buffer_full=1 for 10 cycles -> mem_wr stays 0 and the pending fetch is not served; after full drops, one write of 0x41 occurs.
- Rollback: clear=1 on the 3rd cycle of a fetch -> no if_valid, mem_wr stays 0, IDLE next cycle. clear during a word store -> all 4 bytes are still written and lsb_valid pulses.
- Async reset: rst=0 mid word-store -> mem_wr=0 and all outputs reset without a clock edge; after release, a fetch completes normally.
